// File: rtl/pe_arr_seq.sv
// pe_arr_seq: sequencer that streams K operand steps into PE_ARR with diagonal skew, one fire pulse and a done pulse.
// Ports: clk, rst (async, active-high), start, clear (sync abort), k_len -> busy, done;
//        buf_rd_en/buf_addr -> operand buffers, buf_w_data/buf_a_data <- buffers (1-cycle read latency);
//        arr_fire, arr_w, arr_a -> PE_ARR.
module pe_arr_seq #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int KW     = 8,
  parameter int PE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 buf_rd_en,
  output logic [KW-1:0]        buf_addr,
  input  logic [COLS*8-1:0]    buf_w_data,
  input  logic [ROWS*8-1:0]    buf_a_data,
  output logic                 arr_fire,
  output logic [COLS*8-1:0]    arr_w,
  output logic [ROWS*8-1:0]    arr_a
);
  localparam int D = ROWS + COLS + PE_LAT - 1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
  state_t state, nxt;
  logic [KW-1:0] step, cnt, k_q;
  logic rd_q, fire_q;
  logic [COLS*8-1:0] w_in;
  logic [ROWS*8-1:0] a_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = clear ? S_IDLE :
          state == S_IDLE  ? (start ? (k_len != '0 ? S_LOAD : S_DONE) : S_IDLE) :
          state == S_LOAD  ? (step == k_q - 1'b1 ? S_DRAIN : S_LOAD) :
          state == S_DRAIN ? (cnt == KW'(D - 1) ? S_DONE : S_DRAIN) :
          S_IDLE;
  always_comb begin
    busy      = state != S_IDLE;
    done      = state == S_DONE;
    buf_rd_en = state == S_LOAD;
    buf_addr  = buf_rd_en ? step : '0;
    arr_fire  = fire_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step   <= '0;
      cnt    <= '0;
      k_q    <= '0;
      rd_q   <= 1'b0;
      fire_q <= 1'b0;
    end else if (clear) begin
      step   <= '0;
      cnt    <= '0;
      k_q    <= '0;
      rd_q   <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      rd_q   <= state == S_LOAD;
      fire_q <= state == S_LOAD && step == '0;
      if (state == S_IDLE && start) begin
        k_q  <= k_len;
        step <= '0;
        cnt  <= '0;
      end
      if (state == S_LOAD) step <= step + 1'b1;
      if (state == S_DRAIN) cnt <= cnt + 1'b1;
    end
  // buffer data is only meaningful the cycle after a LOAD read; zeros fill the chain otherwise
  assign w_in = rd_q ? buf_w_data : '0;
  assign a_in = rd_q ? buf_a_data : '0;
  genvar i;
  for (i = 0; i < COLS; i++) begin : g_w
    if (i == 0) begin : g_z
      assign arr_w[7:0] = w_in[7:0];
    end else begin : g_d
      logic [7:0] p [i];
      always_ff @(posedge clk or posedge rst)
        if (rst) p <= '{default: '0};
        else if (clear) p <= '{default: '0};
        else begin
          p[0] <= w_in[8*i +: 8];
          for (int k = 1; k < i; k++) p[k] <= p[k-1];
        end
      assign arr_w[8*i +: 8] = p[i-1];
    end
  end
  for (i = 0; i < ROWS; i++) begin : g_a
    if (i == 0) begin : g_z
      assign arr_a[7:0] = a_in[7:0];
    end else begin : g_d
      logic [7:0] p [i];
      always_ff @(posedge clk or posedge rst)
        if (rst) p <= '{default: '0};
        else if (clear) p <= '{default: '0};
        else begin
          p[0] <= a_in[8*i +: 8];
          for (int k = 1; k < i; k++) p[k] <= p[k-1];
        end
      assign arr_a[8*i +: 8] = p[i-1];
    end
  end
endmodule

// File: tb/tb_pe_arr_seq.sv
// tb_pe_arr_seq: directed table-driven bench for pe_arr_seq (ROWS=COLS=8, PE_LAT=1, D=16).
module tb_pe_arr_seq;
  localparam int NC = 45;
  logic clk = 0, rst = 1, start = 0, clear = 0;
  logic [7:0] k_len = 0;
  logic busy, done, buf_rd_en, arr_fire;
  logic [7:0] buf_addr;
  logic [63:0] bw = '0, ba = '0, arr_w, arr_a;
  logic cap_rd [NC], cap_fire [NC], cap_done [NC], cap_busy [NC];
  logic [7:0] cap_addr [NC];
  logic [63:0] cap_w [NC], cap_a [NC];
  int checks = 0, failures = 0;
  typedef struct {
    int k;
    int done_cyc;
  } vec_t;
  vec_t tv [5];
  pe_arr_seq dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .k_len(k_len),
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_addr(buf_addr),
    .buf_w_data(bw), .buf_a_data(ba), .arr_fire(arr_fire), .arr_w(arr_w), .arr_a(arr_a)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] wpat(int s, int j);
    return 8'(s + 1 + 16 * j);
  endfunction
  function automatic logic [7:0] apat(int s, int j);
    return 8'(200 - s - 16 * j);
  endfunction
  always @(posedge clk)
    if (buf_rd_en)
      for (int j = 0; j < 8; j++) begin
        bw[8*j +: 8] <= wpat(int'(buf_addr), j);
        ba[8*j +: 8] <= apat(int'(buf_addr), j);
      end
  task automatic chk(input string n, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h want %h", n, c, act, exp);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, 0, {60'd0, busy, done, buf_rd_en, arr_fire}, 64'd0);
    chk({n, "_addr"}, 0, 64'(buf_addr), 64'd0);
    chk({n, "_w"}, 0, arr_w, 64'd0);
    chk({n, "_a"}, 0, arr_a, 64'd0);
  endtask
  // start high at cycle 0 and again for cycles lo..hi; outputs captured mid-cycle for cycles 1..NC-1
  task automatic run_pass(input int k, input int lo, input int hi);
    @(negedge clk);
    start = 1;
    k_len = 8'(k);
    for (int c = 1; c < NC; c++) begin
      @(negedge clk);
      cap_rd[c] = buf_rd_en;
      cap_addr[c] = buf_addr;
      cap_fire[c] = arr_fire;
      cap_done[c] = done;
      cap_busy[c] = busy;
      cap_w[c] = arr_w;
      cap_a[c] = arr_a;
      start = c >= lo && c <= hi;
    end
    start = 0;
  endtask
  task automatic check_pass(input int k, input int dc);
    for (int c = 1; c < NC; c++) begin
      chk("rd_en", c, 64'(cap_rd[c]), 64'(c >= 1 && c <= k));
      if (c >= 1 && c <= k) chk("addr", c, 64'(cap_addr[c]), 64'(c - 1));
      chk("fire", c, 64'(cap_fire[c]), 64'(k > 0 && c == 2));
      chk("done", c, 64'(cap_done[c]), 64'(c == dc));
      chk("busy", c, 64'(cap_busy[c]), 64'(c >= 1 && c <= dc));
      for (int j = 0; j < 8; j++) begin
        int s;
        s = c - 2 - j;
        chk($sformatf("w_lane%0d", j), c, 64'(cap_w[c][8*j +: 8]), 64'((s >= 0 && s < k) ? wpat(s, j) : 8'd0));
        chk($sformatf("a_lane%0d", j), c, 64'(cap_a[c][8*j +: 8]), 64'((s >= 0 && s < k) ? apat(s, j) : 8'd0));
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tv[0] = '{k: 4, done_cyc: 21};
    tv[1] = '{k: 3, done_cyc: 20};
    tv[2] = '{k: 1, done_cyc: 18};
    tv[3] = '{k: 0, done_cyc: 1};
    tv[4] = '{k: 10, done_cyc: 27};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    chk_zero("post_reset");
    for (int n = 0; n < 5; n++) begin
      run_pass(tv[n].k, 1, 0);
      check_pass(tv[n].k, tv[n].done_cyc);
    end
    // K=3 skew corners by hand
    run_pass(3, 1, 0);
    chk("w7_hand", 8, 64'(cap_w[8][63:56]), 64'd0);
    chk("w7_hand", 9, 64'(cap_w[9][63:56]), 64'd113);
    chk("w7_hand", 10, 64'(cap_w[10][63:56]), 64'd114);
    chk("w7_hand", 11, 64'(cap_w[11][63:56]), 64'd115);
    chk("w7_hand", 12, 64'(cap_w[12][63:56]), 64'd0);
    chk("a0_hand", 2, 64'(cap_a[2][7:0]), 64'd200);
    chk("a0_hand", 3, 64'(cap_a[3][7:0]), 64'd199);
    chk("a0_hand", 4, 64'(cap_a[4][7:0]), 64'd198);
    // start re-asserted while busy is ignored
    run_pass(4, 5, 15);
    check_pass(4, 21);
    // clear at cycle 6 of a K=8 pass
    @(negedge clk);
    start = 1;
    k_len = 8'd8;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      clear = c == 6;
    end
    @(negedge clk);
    clear = 0;
    chk_zero("after_clear");
    run_pass(2, 1, 0);
    check_pass(2, 19);
    // async reset mid-DRAIN
    @(negedge clk);
    start = 1;
    k_len = 8'd4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 0;
    end
    chk("pre_rst_busy", 10, 64'(busy), 64'd1);
    #2 rst = 1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_zero("after_rst");
    run_pass(1, 1, 0);
    check_pass(1, 18);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
